// File: rtl/hisoc_arb_pkg.sv
// -----------------------------------------------------------------------------
// hisoc_arb_pkg
// Shared types and constants for the HISOC SRAM arbiter:
//   - arb_state_t : run/hold sequencer state encodings
//   - ID_M0/ID_M1 : requester identifiers (fetch / load-store unit)
//   - sat_inc32   : saturating 32-bit increment used by the stall counters
// -----------------------------------------------------------------------------
package hisoc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hisoc_rr_arb2.sv
// -----------------------------------------------------------------------------
// hisoc_rr_arb2
// Two-way round-robin arbiter with its pointer register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointer -> ID_M0)
//   en        : arbitration enabled (no grants and no pointer update when 0)
//   req[1:0]  : request vector, bit ID_M0 = fetch, bit ID_M1 = load/store
//   gnt_vld   : a grant is issued this cycle
//   gnt_id    : identifier of the granted requester (valid with gnt_vld)
// -----------------------------------------------------------------------------
module hisoc_rr_arb2
    import hisoc_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic rr_ptr_reg;
    logic rr_ptr_next;

    always_comb begin
        gnt_vld     = en && (|req);
        gnt_id      = rr_ptr_reg;
        // A lone requester wins regardless of the pointer; on contention the
        // pointer decides.
        if (req == 2'b01)
            gnt_id = ID_M0;
        else if (req == 2'b10)
            gnt_id = ID_M1;
        // After any grant the other requester gets priority next time.
        rr_ptr_next = gnt_vld ? ~gnt_id : rr_ptr_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr_reg <= ID_M0;
        else
            rr_ptr_reg <= rr_ptr_next;
    end

endmodule

// File: rtl/hisoc_mem_arb.sv
// -----------------------------------------------------------------------------
// hisoc_mem_arb
// Shares the single-port, 1-cycle-latency HISOC instruction/data SRAM between
// the program loader, the core fetch port (m0) and the core LSU (m1), and owns
// the core run/hold sequence IDLE -> LOAD -> RUN (-> DRAIN -> LOAD ...).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ld_start / ld_done       : loader sequencing pulses
//   ld_req_*                 : loader write-only request port
//   m0_req_* / m0_rsp_*      : fetch read port
//   m1_req_* / m1_rsp_*      : LSU read/write port (write ack returns data 0)
//   core_en                  : core run enable (high only in RUN)
//   mem_*                    : SRAM interface, request side combinational
//   perf_m0/m1_stall         : RUN-state stall counters, only when the
//                              HISOC_ARB_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module hisoc_mem_arb
    import hisoc_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_done,
    input  logic              ld_req_vld,
    output logic              ld_req_rdy,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [DATA_W-1:0] ld_req_wdata,
    input  logic              m0_req_vld,
    output logic              m0_req_rdy,
    input  logic [ADDR_W-1:0] m0_req_addr,
    output logic              m0_rsp_vld,
    output logic [DATA_W-1:0] m0_rsp_data,
    input  logic              m1_req_vld,
    output logic              m1_req_rdy,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    input  logic [3:0]        m1_req_wstrb,
    output logic              m1_rsp_vld,
    output logic [DATA_W-1:0] m1_rsp_data,
    output logic              core_en,
`ifdef HISOC_ARB_PERF_EN
    output logic [31:0]       perf_m0_stall,
    output logic [31:0]       perf_m1_stall,
`endif
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_reg, state_next;
    logic       pend_vld_reg, pend_vld_next;
    logic       pend_id_reg, pend_id_next;
    logic       pend_we_reg, pend_we_next;

    logic       gnt_vld;
    logic       gnt_id;

    // Byte-lane and out-of-range address bits are intentionally dropped.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{ld_req_addr, m0_req_addr, m1_req_addr};

    hisoc_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .en      (state_reg == ST_RUN),
        .req     ({m1_req_vld, m0_req_vld}),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pend_vld_reg <= 1'b0;
            pend_id_reg  <= ID_M0;
            pend_we_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_vld_reg <= pend_vld_next;
            pend_id_reg  <= pend_id_next;
            pend_we_reg  <= pend_we_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        // Only the pulse relevant to the current state is looked at, so a
        // coincident ld_start/ld_done resolves to a single transition.
        case (state_reg)
            ST_IDLE:  if (ld_start)      state_next = ST_LOAD;
            ST_LOAD:  if (ld_done)       state_next = ST_RUN;
            ST_RUN:   if (ld_start)      state_next = ST_DRAIN;
            ST_DRAIN: if (!pend_vld_reg) state_next = ST_LOAD;
            default:                     state_next = ST_IDLE;
        endcase

        // Every core grant expects a response the following cycle.
        pend_vld_next = gnt_vld;
        pend_id_next  = gnt_id;
        pend_we_next  = gnt_vld && (gnt_id == ID_M1) && m1_req_we;
    end

    // ---------------- output / mux logic ----------------
    always_comb begin
        core_en    = 1'b0;
        ld_req_rdy = 1'b0;
        m0_req_rdy = 1'b0;
        m1_req_rdy = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'h0;
        case (state_reg)
            ST_LOAD: begin
                ld_req_rdy = ld_req_vld;
                mem_cs     = ld_req_vld;
                mem_we     = ld_req_vld;
                if (ld_req_vld) begin
                    mem_addr  = ld_req_addr[MEM_AW+1:2];
                    mem_wdata = ld_req_wdata;
                    mem_wstrb = 4'hF;
                end
            end
            ST_RUN: begin
                core_en = 1'b1;
                if (gnt_vld) begin
                    mem_cs = 1'b1;
                    if (gnt_id == ID_M0) begin
                        m0_req_rdy = 1'b1;
                        mem_addr   = m0_req_addr[MEM_AW+1:2];
                    end else begin
                        m1_req_rdy = 1'b1;
                        mem_we     = m1_req_we;
                        mem_addr   = m1_req_addr[MEM_AW+1:2];
                        if (m1_req_we) begin
                            mem_wdata = m1_req_wdata;
                            mem_wstrb = m1_req_wstrb;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Responses: routed by the pending id; data forced to 0 when not valid
    // and for write acknowledges.
    assign m0_rsp_vld  = pend_vld_reg && (pend_id_reg == ID_M0);
    assign m1_rsp_vld  = pend_vld_reg && (pend_id_reg == ID_M1);
    assign m0_rsp_data = m0_rsp_vld ? mem_rdata : '0;
    assign m1_rsp_data = (m1_rsp_vld && !pend_we_reg) ? mem_rdata : '0;

`ifdef HISOC_ARB_PERF_EN
    logic load_entry;
    assign load_entry = (state_next == ST_LOAD) && (state_reg != ST_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_m0_stall <= 32'd0;
            perf_m1_stall <= 32'd0;
        end else if (load_entry) begin
            perf_m0_stall <= 32'd0;
            perf_m1_stall <= 32'd0;
        end else if (state_reg == ST_RUN) begin
            if (m0_req_vld && !m0_req_rdy)
                perf_m0_stall <= sat_inc32(perf_m0_stall);
            if (m1_req_vld && !m1_req_rdy)
                perf_m1_stall <= sat_inc32(perf_m1_stall);
        end
    end
`endif

endmodule

// File: tb/tb_hisoc_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_hisoc_mem_arb
// Directed bench for hisoc_mem_arb. Inputs change on the falling edge; outputs
// are checked 1 time unit later. A tiny SRAM stand-in returns
// 0x1000_0000 | word_address one cycle after a read select.
// -----------------------------------------------------------------------------
module tb_hisoc_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_done;
    logic        ld_req_vld, ld_req_rdy;
    logic [31:0] ld_req_addr, ld_req_wdata;
    logic        m0_req_vld, m0_req_rdy;
    logic [31:0] m0_req_addr;
    logic        m0_rsp_vld;
    logic [31:0] m0_rsp_data;
    logic        m1_req_vld, m1_req_rdy, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m1_rsp_vld;
    logic [31:0] m1_rsp_data;
    logic        core_en;
    logic        mem_cs, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
`ifdef HISOC_ARB_PERF_EN
    logic [31:0] perf_m0_stall, perf_m1_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hisoc_mem_arb dut (
        .clk          (clk),
        .rst          (rst),
        .ld_start     (ld_start),
        .ld_done      (ld_done),
        .ld_req_vld   (ld_req_vld),
        .ld_req_rdy   (ld_req_rdy),
        .ld_req_addr  (ld_req_addr),
        .ld_req_wdata (ld_req_wdata),
        .m0_req_vld   (m0_req_vld),
        .m0_req_rdy   (m0_req_rdy),
        .m0_req_addr  (m0_req_addr),
        .m0_rsp_vld   (m0_rsp_vld),
        .m0_rsp_data  (m0_rsp_data),
        .m1_req_vld   (m1_req_vld),
        .m1_req_rdy   (m1_req_rdy),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_req_wstrb (m1_req_wstrb),
        .m1_rsp_vld   (m1_rsp_vld),
        .m1_rsp_data  (m1_rsp_data),
        .core_en      (core_en),
`ifdef HISOC_ARB_PERF_EN
        .perf_m0_stall(perf_m0_stall),
        .perf_m1_stall(perf_m1_stall),
`endif
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    // SRAM stand-in: recognisable read data per word address.
    always @(posedge clk) begin
        if (mem_cs && !mem_we)
            mem_rdata <= 32'h1000_0000 | {20'h0, mem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic exp_m0;
        logic prev_m0;
        bit   in_load;

        rst = 1'b1;
        ld_start = 0; ld_done = 0;
        ld_req_vld = 0; ld_req_addr = 0; ld_req_wdata = 0;
        m0_req_vld = 1; m0_req_addr = 32'h10;
        m1_req_vld = 0; m1_req_we = 0; m1_req_addr = 32'h200;
        m1_req_wdata = 0; m1_req_wstrb = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_mem_cs", 32'(mem_cs), 0);
        chk("rst_m0_rdy", 32'(m0_req_rdy), 0);
        chk("rst_m0_rsp", 32'(m0_rsp_vld), 0);
        rst = 1'b0;

        // ---------------- IDLE: no grant, then ld_start ----------------
        @(negedge clk); #1;
        chk("idle_m0_rdy", 32'(m0_req_rdy), 0);
        ld_start = 1;
        #1 chk("idle_core_en", 32'(core_en), 0);

        // ---------------- LOAD: three loader writes ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_start = 0;
            ld_req_vld = 1; ld_req_addr = 32'(i * 4); ld_req_wdata = 32'h0000_0013;
            #1;
            $display("txn ld_wr addr=%h data=%h mem_addr=%0d", ld_req_addr, ld_req_wdata, mem_addr);
            chk("ld_rdy", 32'(ld_req_rdy), 1);
            chk("ld_we", 32'(mem_we), 1);
            chk("ld_addr", 32'(mem_addr), 32'(i));
            chk("ld_wstrb", 32'(mem_wstrb), 32'hF);
            chk("ld_wdata", mem_wdata, 32'h13);
            chk("ld_m0_rdy", 32'(m0_req_rdy), 0);
            chk("ld_core_en", 32'(core_en), 0);
        end
        @(negedge clk);
        ld_req_vld = 0; ld_done = 1; m0_req_vld = 0;
        #1;
        chk("lddone_core_en", 32'(core_en), 0);
        chk("lddone_we", 32'(mem_we), 0);

        // ---------------- RUN entry ----------------
        @(negedge clk);
        ld_done = 0;
        #1;
        chk("run_core_en", 32'(core_en), 1);
        chk("run_idle_cs", 32'(mem_cs), 0);

        // ---------------- RUN: both read continuously ----------------
        prev_m0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m0_req_vld = 1; m0_req_addr = 32'h10;
            m1_req_vld = 1; m1_req_we = 0; m1_req_addr = 32'h200;
            #1;
            exp_m0 = (k % 2 == 0);
            $display("txn rr k=%0d m0_rdy=%0b m1_rdy=%0b mem_addr=%0d", k, m0_req_rdy, m1_req_rdy, mem_addr);
            chk("rr_m0_rdy", 32'(m0_req_rdy), 32'(exp_m0));
            chk("rr_m1_rdy", 32'(m1_req_rdy), 32'(!exp_m0));
            chk("rr_addr", 32'(mem_addr), exp_m0 ? 32'd4 : 32'd128);
            chk("rr_we", 32'(mem_we), 0);
            if (k == 0) begin
                chk("rr_rsp0_m0", 32'(m0_rsp_vld), 0);
                chk("rr_rsp0_m1", 32'(m1_rsp_vld), 0);
            end else if (prev_m0) begin
                chk("rr_m0_rsp", 32'(m0_rsp_vld), 1);
                chk("rr_m0_data", m0_rsp_data, 32'h1000_0004);
                chk("rr_m1_norsp", 32'(m1_rsp_vld), 0);
            end else begin
                chk("rr_m1_rsp", 32'(m1_rsp_vld), 1);
                chk("rr_m1_data", m1_rsp_data, 32'h1000_0080);
                chk("rr_m0_norsp", 32'(m0_rsp_vld), 0);
            end
            prev_m0 = exp_m0;
        end
        @(negedge clk);
        m0_req_vld = 0; m1_req_vld = 0;
        #1;
        chk("rr_last_m1_rsp", 32'(m1_rsp_vld), 1);
        chk("rr_last_m1_data", m1_rsp_data, 32'h1000_0080);
        chk("rr_last_cs", 32'(mem_cs), 0);
`ifdef HISOC_ARB_PERF_EN
        chk("perf_m1_stall", perf_m1_stall, 32'd5);
        chk("perf_m0_stall", perf_m0_stall, 32'd5);
`endif

        // ---------------- RUN: m1 partial write ----------------
        @(negedge clk);
        m1_req_vld = 1; m1_req_we = 1; m1_req_addr = 32'h40;
        m1_req_wdata = 32'hDEAD_BEEF; m1_req_wstrb = 4'b0011;
        #1;
        $display("txn m1_wr addr=%h data=%h strb=%b", m1_req_addr, m1_req_wdata, m1_req_wstrb);
        chk("wr_rdy", 32'(m1_req_rdy), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 32'd16);
        chk("wr_wstrb", 32'(mem_wstrb), 32'b0011);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        m1_req_vld = 0; m1_req_we = 0;
        #1;
        chk("wr_ack_vld", 32'(m1_rsp_vld), 1);
        chk("wr_ack_data", m1_rsp_data, 32'h0);
        chk("wr_ack_m0", 32'(m0_rsp_vld), 0);

        // ---------------- ld_start with m0 grant -> DRAIN -> LOAD ----------
        @(negedge clk);
        m0_req_vld = 1; m0_req_addr = 32'h10; ld_start = 1;
        ld_req_vld = 1; ld_req_addr = 32'h20; ld_req_wdata = 32'h55;
        #1;
        chk("drn_grant", 32'(m0_req_rdy), 1);
        chk("drn_pre_core_en", 32'(core_en), 1);
        chk("drn_pre_ld_rdy", 32'(ld_req_rdy), 0);
        @(negedge clk);
        ld_start = 0;
        #1;
        chk("drn_core_en", 32'(core_en), 0);
        chk("drn_m0_rdy", 32'(m0_req_rdy), 0);
        chk("drn_cs", 32'(mem_cs), 0);
        chk("drn_rsp", 32'(m0_rsp_vld), 1);
        chk("drn_rsp_data", m0_rsp_data, 32'h1000_0004);
        chk("drn_ld_rdy", 32'(ld_req_rdy), 0);
        in_load = 0;
        for (int w = 0; w < 3 && !in_load; w++) begin
            @(negedge clk); #1;
            if (ld_req_rdy) in_load = 1;
            else chk("drn_wait_core_en", 32'(core_en), 0);
        end
        chk("drn_reached_load", 32'(in_load), 1);
        chk("reload_we", 32'(mem_we), 1);
        chk("reload_addr", 32'(mem_addr), 32'd8);
        chk("reload_m0_rdy", 32'(m0_req_rdy), 0);
        chk("reload_m0_rsp", 32'(m0_rsp_vld), 0);
`ifdef HISOC_ARB_PERF_EN
        chk("perf_m1_clr", perf_m1_stall, 32'd0);
        chk("perf_m0_clr", perf_m0_stall, 32'd0);
`endif
        @(negedge clk);
        ld_req_vld = 0; m0_req_vld = 0; ld_done = 1;
        @(negedge clk);
        ld_done = 0;
        #1 chk("rerun_core_en", 32'(core_en), 1);

        // ---------------- reset mid-RUN with a pending read ----------------
        @(negedge clk);
        m0_req_vld = 1; m0_req_addr = 32'h10;
        #1 chk("rstrun_grant", 32'(m0_req_rdy), 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rstrun_rsp", 32'(m0_rsp_vld), 0);
        chk("rstrun_rsp_data", m0_rsp_data, 32'h0);
        chk("rstrun_core_en", 32'(core_en), 0);
        chk("rstrun_cs", 32'(mem_cs), 0);
        chk("rstrun_m0_rdy", 32'(m0_req_rdy), 0);
        @(negedge clk);
        rst = 0; ld_req_vld = 1; ld_req_addr = 32'h0;
        #1;
        chk("post_rst_rsp", 32'(m0_rsp_vld), 0);
        chk("post_rst_core_en", 32'(core_en), 0);
        chk("post_rst_m0_rdy", 32'(m0_req_rdy), 0);
        chk("post_rst_ld_rdy", 32'(ld_req_rdy), 0);
        ld_start = 1;
        @(negedge clk);
        ld_start = 0;
        #1 chk("post_rst_load", 32'(ld_req_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
